// File: rtl/trainer_pkg.sv
// Shared definitions for the 4-register trainer CPU: opcodes, instruction fields, sequencer states.
package trainer_pkg;

  localparam int unsigned INSTR_W = 8;

  localparam logic [3:0] OPCODE_NOP = 4'h0;
  localparam logic [3:0] OPCODE_ADD = 4'h1;
  localparam logic [3:0] OPCODE_SUB = 4'h2;
  localparam logic [3:0] OPCODE_AND = 4'h3;
  localparam logic [3:0] OPCODE_OR  = 4'h4;
  localparam logic [3:0] OPCODE_XOR = 4'h5;
  localparam logic [3:0] OPCODE_NOT = 4'h6;
  localparam logic [3:0] OPCODE_SHL = 4'h7;
  localparam logic [3:0] OPCODE_MOV = 4'h8;
  localparam logic [3:0] OP_HALT    = 4'hF;

  // Sequencer state encodings
  localparam int unsigned SEQ_STATE_W = 2;
  localparam logic [1:0] SEQ_IDLE  = 2'd0;
  localparam logic [1:0] SEQ_FETCH = 2'd1;
  localparam logic [1:0] SEQ_ISSUE = 2'd2;
  localparam logic [1:0] SEQ_HALT  = 2'd3;

  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] dst;
    logic [1:0] src;
  } instr_t;

  function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] w);
    instr_t f;
    f = instr_t'(w);
    return f.opcode;
  endfunction

  function automatic logic [1:0] instr_dst(input logic [INSTR_W-1:0] w);
    instr_t f;
    f = instr_t'(w);
    return f.dst;
  endfunction

  function automatic logic [1:0] instr_src(input logic [INSTR_W-1:0] w);
    instr_t f;
    f = instr_t'(w);
    return f.src;
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Instruction handshake between the sequencer (master) and the CPU (slave).
interface program_sequencer_if #(
  parameter int unsigned IW = 8
);
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic          instr_ready;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/prog_ram.sv
// Program store: one write port, registered read port, contents not reset.
module prog_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned IW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] rdata_q;

  // Write on strobe; read address sampled every cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/program_sequencer.sv
// Stored-program instruction source: load mode fills the RAM, run mode issues in order.
module program_sequencer
  import trainer_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned IW       = 8,
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter bit          WRAP     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode_load,
  input  logic                wr_pulse,
  input  logic [IW-1:0]       wr_data,
  input  logic                step_pulse,
  input  logic                run_en,
  program_sequencer_if.master bus,
  output logic [AW-1:0]       pc,
  output logic [AW:0]         prog_len,
  output logic                full,
  output logic                halted
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [SEQ_STATE_W-1:0] state_q, state_d;
  logic [AW-1:0]          pc_q, pc_d;
  logic [LW-1:0]          prog_len_q, prog_len_d;
  logic                   full_q, full_d;
  logic                   halted_q, halted_d;
  logic                   instr_valid_q, instr_valid_d;
  logic [IW-1:0]          instr_q, instr_d;
  logic                   mode_load_q, mode_load_d;
  logic                   load_pend_q, load_pend_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;

  logic                   tick_c;
  logic                   mem_we;
  logic [AW-1:0]          mem_waddr;
  logic [IW-1:0]          rd_data;

  prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_prog_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (wr_data),
    .raddr (pc_q),
    .rdata (rd_data)
  );

  // Auto-run tick: free-running divider, pulses one cycle at wrap, parked at 0 when disabled
  always_comb begin
    tick_c     = run_en && (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = '0;
    if (run_en && !tick_c) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // Next-state and output logic for load, fetch, issue and halt
  always_comb begin
    logic          load_rise;
    logic          request;
    logic          new_prog;
    logic [LW-1:0] pc_inc;
    logic [LW-1:0] len_base;

    state_d       = state_q;
    pc_d          = pc_q;
    prog_len_d    = prog_len_q;
    halted_d      = halted_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    load_pend_d   = load_pend_q;
    mode_load_d   = mode_load;
    mem_we        = 1'b0;
    mem_waddr     = prog_len_q[AW-1:0];

    load_rise = mode_load && !mode_load_q;
    request   = step_pulse || tick_c;
    new_prog  = load_pend_q || load_rise;
    pc_inc    = {1'b0, pc_q} + LW'(1);
    len_base  = load_rise ? '0 : prog_len_q;

    case (state_q)
      SEQ_IDLE, SEQ_HALT: begin
        load_pend_d = 1'b0;
        if (load_rise) begin
          state_d    = SEQ_IDLE;
          pc_d       = '0;
          prog_len_d = '0;
          halted_d   = 1'b0;
        end
        if (mode_load) begin
          // A write in the same cycle as the new-program edge lands at address 0
          if (wr_pulse && (load_rise || !full_q)) begin
            mem_we     = 1'b1;
            mem_waddr  = len_base[AW-1:0];
            prog_len_d = len_base + LW'(1);
          end
        end else if ((state_q == SEQ_IDLE) && request) begin
          if (prog_len_q == '0) begin
            state_d  = SEQ_HALT;
            halted_d = 1'b1;
          end else if ({1'b0, pc_q} < prog_len_q) begin
            state_d = SEQ_FETCH;
          end
        end
      end

      SEQ_FETCH: begin
        load_pend_d = new_prog;
        if (instr_opcode(rd_data) == OP_HALT) begin
          if (new_prog) begin
            state_d     = SEQ_IDLE;
            pc_d        = '0;
            prog_len_d  = '0;
            halted_d    = 1'b0;
            load_pend_d = 1'b0;
          end else begin
            state_d  = SEQ_HALT;
            halted_d = 1'b1;
          end
        end else begin
          instr_d       = rd_data;
          instr_valid_d = 1'b1;
          state_d       = SEQ_ISSUE;
        end
      end

      SEQ_ISSUE: begin
        load_pend_d = new_prog;
        if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          if (new_prog) begin
            state_d     = SEQ_IDLE;
            pc_d        = '0;
            prog_len_d  = '0;
            halted_d    = 1'b0;
            load_pend_d = 1'b0;
          end else if (pc_inc == prog_len_q) begin
            if (WRAP) begin
              pc_d    = '0;
              state_d = SEQ_IDLE;
            end else begin
              pc_d     = pc_inc[AW-1:0];
              state_d  = SEQ_HALT;
              halted_d = 1'b1;
            end
          end else begin
            pc_d    = pc_inc[AW-1:0];
            state_d = SEQ_IDLE;
          end
        end
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    full_d = (prog_len_d == LW'(DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= SEQ_IDLE;
      pc_q          <= '0;
      prog_len_q    <= '0;
      full_q        <= 1'b0;
      halted_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      mode_load_q   <= 1'b0;
      load_pend_q   <= 1'b0;
      tick_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      prog_len_q    <= prog_len_d;
      full_q        <= full_d;
      halted_q      <= halted_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      mode_load_q   <= mode_load_d;
      load_pend_q   <= load_pend_d;
      tick_cnt_q    <= tick_cnt_d;
    end
  end

  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign pc              = pc_q;
  assign prog_len        = prog_len_q;
  assign full            = full_q;
  assign halted          = halted_q;

endmodule
